// File: rtl/mem_load_align_if.sv
// Data-memory read port between the load unit (master) and data memory (slave).
// Handshake: dm_req is a one-cycle request pulse qualified by dm_addr; the slave later
// answers with a one-cycle dm_rvalid carrying dm_rdata; there is no ready/backpressure.
interface mem_load_align_if;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;

  modport master (output dm_req, output dm_addr, input dm_rvalid, input dm_rdata);
  modport slave  (input dm_req, input dm_addr, output dm_rvalid, output dm_rdata);
endinterface

// File: rtl/mem_load_align.sv
// Memory-stage load unit: issues word-aligned reads, waits for the response and
// extracts/extends the addressed byte or halfword; non-loads pass straight to WB.
module mem_load_align #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  is_load_mem,
  input  logic [31:0] alu_out_mem,
  input  logic [4:0]  rd_addr_mem,
  input  logic        wb_en_mem,
  mem_load_align_if.master dm,
  output logic        stall_mem,
  output logic [31:0] wb_data,
  output logic [4:0]  rd_addr_wb,
  output logic        wb_en_wb,
  output logic        load_misalign,
  output logic        load_timeout,
  output logic        dbg_state
);

  localparam logic [2:0] LD_LW  = 3'b001;
  localparam logic [2:0] LD_LH  = 3'b010;
  localparam logic [2:0] LD_LB  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;
  localparam logic [2:0] LD_LBU = 3'b101;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_e;

  state_e      state;
  logic [CW-1:0] cnt;
  logic [2:0]  ld_type_q;
  logic [1:0]  ld_off_q;
  logic [4:0]  rd_q;
  logic        wen_q;

  logic [1:0]  off;
  logic        is_load;
  logic        misalign;
  logic        issue;
  logic        last_wait;
  logic [31:0] shifted;
  logic [31:0] aligned;

  assign off      = alu_out_mem[1:0];
  assign is_load  = (is_load_mem >= LD_LW) && (is_load_mem <= LD_LBU);
  assign misalign = ((is_load_mem == LD_LW) && (off != 2'b00)) ||
                    (((is_load_mem == LD_LH) || (is_load_mem == LD_LHU)) && (off == 2'b11));
  assign issue    = (state == IDLE) && is_load && !misalign;
  assign last_wait = (cnt == CNT_LAST);

  assign dm.dm_req  = issue;
  assign dm.dm_addr = {alu_out_mem[31:2], 2'b00};
  // The final WAIT cycle releases the stall so the pipeline moves on with the timeout.
  assign stall_mem  = issue || ((state == WAIT) && !dm.dm_rvalid && !last_wait);
  assign dbg_state  = state;

  // Byte lanes mirror the store path, which shifts data left by the offset.
  assign shifted = dm.dm_rdata >> {ld_off_q, 3'b000};

  always_comb begin
    aligned = dm.dm_rdata;
    case (ld_type_q)
      LD_LH:   aligned = {{16{shifted[15]}}, shifted[15:0]};
      LD_LHU:  aligned = {16'h0000, shifted[15:0]};
      LD_LB:   aligned = {{24{shifted[7]}}, shifted[7:0]};
      LD_LBU:  aligned = {24'h000000, shifted[7:0]};
      default: aligned = dm.dm_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      ld_type_q     <= '0;
      ld_off_q      <= '0;
      rd_q          <= '0;
      wen_q         <= 1'b0;
      wb_data       <= '0;
      rd_addr_wb    <= '0;
      wb_en_wb      <= 1'b0;
      load_misalign <= 1'b0;
      load_timeout  <= 1'b0;
    end else begin
      load_misalign <= 1'b0;
      load_timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (!is_load) begin
            wb_data    <= alu_out_mem;
            rd_addr_wb <= rd_addr_mem;
            wb_en_wb   <= wb_en_mem;
          end else if (misalign) begin
            wb_en_wb      <= 1'b0;
            load_misalign <= 1'b1;
          end else begin
            ld_type_q <= is_load_mem;
            ld_off_q  <= off;
            rd_q      <= rd_addr_mem;
            wen_q     <= wb_en_mem;
            cnt       <= '0;
            wb_en_wb  <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (dm.dm_rvalid) begin
            wb_data    <= aligned;
            rd_addr_wb <= rd_q;
            wb_en_wb   <= wen_q;
            state      <= IDLE;
          end else if (last_wait) begin
            wb_en_wb     <= 1'b0;
            load_timeout <= 1'b1;
            state        <= IDLE;
          end else begin
            wb_en_wb <= 1'b0;
            cnt      <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_load_align.sv
// Directed bench for mem_load_align with TIMEOUT=4 and a hand-driven memory response.
module tb_mem_load_align;

  logic        clk;
  logic        rst_n;
  logic [2:0]  is_load_mem;
  logic [31:0] alu_out_mem;
  logic [4:0]  rd_addr_mem;
  logic        wb_en_mem;
  logic        stall_mem;
  logic [31:0] wb_data;
  logic [4:0]  rd_addr_wb;
  logic        wb_en_wb;
  logic        load_misalign;
  logic        load_timeout;
  logic        dbg_state;

  int chk_cnt;
  int pass_cnt;

  mem_load_align_if dm_if();

  mem_load_align #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .is_load_mem(is_load_mem), .alu_out_mem(alu_out_mem),
    .rd_addr_mem(rd_addr_mem), .wb_en_mem(wb_en_mem),
    .dm(dm_if.master),
    .stall_mem(stall_mem), .wb_data(wb_data), .rd_addr_wb(rd_addr_wb),
    .wb_en_wb(wb_en_wb), .load_misalign(load_misalign),
    .load_timeout(load_timeout), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] ld, input logic [31:0] a,
                       input logic [4:0] rd, input logic we);
    is_load_mem = ld;
    alu_out_mem = a;
    rd_addr_mem = rd;
    wb_en_mem   = we;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dm_if.dm_rvalid = 1'b0;
    dm_if.dm_rdata  = '0;
    drive(3'b000, 32'h0, 5'd0, 1'b0);
    #20;
    chk_cnt++; if ({wb_data, rd_addr_wb, wb_en_wb} !== 38'h0) $display("FAIL rst_wb: got %h/%h/%b want 0", wb_data, rd_addr_wb, wb_en_wb); else pass_cnt++;
    chk_cnt++; if ({load_misalign, load_timeout, stall_mem, dm_if.dm_req, dbg_state} !== 5'b0) $display("FAIL rst_ctl: got %b want 00000", {load_misalign, load_timeout, stall_mem, dm_if.dm_req, dbg_state}); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_passthrough();
    drive(3'b000, 32'h1234_5678, 5'd5, 1'b1);
    chk_cnt++; if ({dm_if.dm_req, stall_mem} !== 2'b00) $display("FAIL pt_req: got %b want 00", {dm_if.dm_req, stall_mem}); else pass_cnt++;
    tick();
    chk_cnt++; if (wb_data !== 32'h1234_5678) $display("FAIL pt_data: got %h want 12345678", wb_data); else pass_cnt++;
    chk_cnt++; if ({rd_addr_wb, wb_en_wb} !== {5'd5, 1'b1}) $display("FAIL pt_rd: got %0d/%b want 5/1", rd_addr_wb, wb_en_wb); else pass_cnt++;
  endtask

  task automatic test_load(input string nm, input logic [2:0] ld, input logic [31:0] a,
                           input logic [4:0] rd, input logic [31:0] rdata,
                           input logic [31:0] exp_addr, input logic [31:0] exp_data);
    drive(ld, a, rd, 1'b1);
    chk_cnt++; if ({dm_if.dm_req, stall_mem} !== 2'b11) $display("FAIL %s_req: got %b want 11", nm, {dm_if.dm_req, stall_mem}); else pass_cnt++;
    chk_cnt++; if (dm_if.dm_addr !== exp_addr) $display("FAIL %s_addr: got %h want %h", nm, dm_if.dm_addr, exp_addr); else pass_cnt++;
    tick();
    chk_cnt++; if ({dm_if.dm_req, wb_en_wb, dbg_state} !== 3'b001) $display("FAIL %s_wait: got %b want 001", nm, {dm_if.dm_req, wb_en_wb, dbg_state}); else pass_cnt++;
    dm_if.dm_rvalid = 1'b1;
    dm_if.dm_rdata  = rdata;
    #1;
    chk_cnt++; if (stall_mem !== 1'b0) $display("FAIL %s_stall: got %b want 0", nm, stall_mem); else pass_cnt++;
    tick();
    dm_if.dm_rvalid = 1'b0;
    drive(3'b000, 32'h0, 5'd0, 1'b0);
    chk_cnt++; if (wb_data !== exp_data) $display("FAIL %s_data: got %h want %h", nm, wb_data, exp_data); else pass_cnt++;
    chk_cnt++; if ({rd_addr_wb, wb_en_wb} !== {rd, 1'b1}) $display("FAIL %s_rd: got %0d/%b want %0d/1", nm, rd_addr_wb, wb_en_wb, rd); else pass_cnt++;
    tick();
  endtask

  task automatic test_misalign(input string nm, input logic [2:0] ld, input logic [31:0] a);
    drive(3'b000, 32'h0, 5'd1, 1'b1);
    tick();
    drive(ld, a, 5'd6, 1'b1);
    chk_cnt++; if ({dm_if.dm_req, stall_mem} !== 2'b00) $display("FAIL %s_req: got %b want 00", nm, {dm_if.dm_req, stall_mem}); else pass_cnt++;
    tick();
    chk_cnt++; if ({load_misalign, load_timeout, wb_en_wb, dbg_state} !== 4'b1000) $display("FAIL %s_pulse: got %b want 1000", nm, {load_misalign, load_timeout, wb_en_wb, dbg_state}); else pass_cnt++;
    drive(3'b000, 32'h0, 5'd0, 1'b0);
    tick();
    chk_cnt++; if (load_misalign !== 1'b0) $display("FAIL %s_one: got %b want 0", nm, load_misalign); else pass_cnt++;
  endtask

  task automatic test_timeout();
    drive(3'b001, 32'h0000_0500, 5'd7, 1'b1);
    chk_cnt++; if ({dm_if.dm_req, stall_mem} !== 2'b11) $display("FAIL to_req: got %b want 11", {dm_if.dm_req, stall_mem}); else pass_cnt++;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk_cnt++; if ({stall_mem, load_timeout, dm_if.dm_req} !== {(i < 3), 2'b00}) $display("FAIL to_wait%0d: got %b want %b", i, {stall_mem, load_timeout, dm_if.dm_req}, {(i < 3), 2'b00}); else pass_cnt++;
      tick();
    end
    chk_cnt++; if ({load_timeout, load_misalign, wb_en_wb, dbg_state} !== 4'b1000) $display("FAIL to_pulse: got %b want 1000", {load_timeout, load_misalign, wb_en_wb, dbg_state}); else pass_cnt++;
    drive(3'b000, 32'hAAAA_0001, 5'd2, 1'b0);
    dm_if.dm_rvalid = 1'b1;
    dm_if.dm_rdata  = 32'hFFFF_FFFF;
    tick();
    dm_if.dm_rvalid = 1'b0;
    chk_cnt++; if ({load_timeout, stall_mem, dbg_state} !== 3'b000) $display("FAIL to_late: got %b want 000", {load_timeout, stall_mem, dbg_state}); else pass_cnt++;
    chk_cnt++; if ({wb_data, rd_addr_wb, wb_en_wb} !== {32'hAAAA_0001, 5'd2, 1'b0}) $display("FAIL to_late_wb: got %h/%0d/%b want aaaa0001/2/0", wb_data, rd_addr_wb, wb_en_wb); else pass_cnt++;
  endtask

  task automatic test_reset_mid_wait();
    drive(3'b000, 32'h0000_CAFE, 5'd3, 1'b1);
    tick();
    drive(3'b001, 32'h0000_0600, 5'd9, 1'b1);
    tick();
    chk_cnt++; if (dbg_state !== 1'b1) $display("FAIL rmw_state: got %b want 1", dbg_state); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if ({wb_data, rd_addr_wb, wb_en_wb, load_misalign, load_timeout, dbg_state} !== 42'h0) $display("FAIL rmw_out: got %h/%h/%b/%b/%b/%b want 0", wb_data, rd_addr_wb, wb_en_wb, load_misalign, load_timeout, dbg_state); else pass_cnt++;
    drive(3'b000, 32'h0000_55AA, 5'd4, 1'b1);
    rst_n = 1'b1;
    dm_if.dm_rvalid = 1'b1;
    dm_if.dm_rdata  = 32'h1111_2222;
    tick();
    dm_if.dm_rvalid = 1'b0;
    chk_cnt++; if ({wb_data, rd_addr_wb, wb_en_wb} !== {32'h0000_55AA, 5'd4, 1'b1}) $display("FAIL rmw_pt: got %h/%0d/%b want 000055aa/4/1", wb_data, rd_addr_wb, wb_en_wb); else pass_cnt++;
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    test_reset();
    test_passthrough();
    test_load("lb",  3'b011, 32'h0000_0103, 5'd10, 32'h80AA_BBCC, 32'h0000_0100, 32'hFFFF_FF80);
    test_load("lbu", 3'b101, 32'h0000_0103, 5'd11, 32'h80AA_BBCC, 32'h0000_0100, 32'h0000_0080);
    test_load("lh",  3'b010, 32'h0000_0201, 5'd12, 32'h00F0_0F00, 32'h0000_0200, 32'hFFFF_F00F);
    test_load("lhu", 3'b100, 32'h0000_0302, 5'd13, 32'h8001_0000, 32'h0000_0300, 32'h0000_8001);
    test_load("lw",  3'b001, 32'h0000_0404, 5'd14, 32'hDEAD_BEEF, 32'h0000_0404, 32'hDEAD_BEEF);
    test_load("lb0", 3'b011, 32'h0000_0500, 5'd15, 32'h1234_567F, 32'h0000_0500, 32'h0000_007F);
    test_misalign("mis_lw", 3'b001, 32'h0000_0102);
    test_misalign("mis_lh", 3'b010, 32'h0000_0103);
    test_timeout();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_load_align.md
# mem_load_align

Memory-stage load unit sitting between the EX/MEM pipeline register and the MEM/WB register. Issues word-aligned reads to data memory, waits for the read response, and extracts and sign- or zero-extends the addressed byte/halfword using the low address bits. Passes non-load results straight through to writeback. Stalls the pipeline while a read is outstanding.

## Interface
Parameters:
- TIMEOUT, 16, max cycles spent in WAIT before the read is abandoned (≥2)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- is_load_mem  in  3  000 none, 001 LW, 010 LH, 011 LB, 100 LHU, 101 LBU; 110/111 treated as none
- alu_out_mem  in  32  load address, or ALU result for non-loads
- rd_addr_mem  in  5  destination register
- wb_en_mem  in  1  register-write enable from EX/MEM
- dm_req  out  1  one-cycle read request pulse
- dm_addr  out  32  {alu_out_mem[31:2],2'b00}
- dm_rvalid  in  1  read data valid, ≥1 cycle after dm_req
- dm_rdata  in  32  read word
- stall_mem  out  1  hold EX/MEM and earlier stages
- wb_data  out  32  registered writeback data
- rd_addr_wb  out  5  registered destination
- wb_en_wb  out  1  registered write enable
- load_misalign  out  1  registered one-cycle error pulse
- load_timeout  out  1  registered one-cycle error pulse

## Operation
- States: IDLE, WAIT. Reset → IDLE.
- IDLE, non-load: next edge wb_data←alu_out_mem, rd_addr_wb←rd_addr_mem, wb_en_wb←wb_en_mem. No request. stall_mem=0.
- IDLE, load, misaligned (LW with offset≠00; LH/LHU with offset 11): no request. Next edge wb_en_wb←0, load_misalign←1. Stay IDLE. stall_mem=0.
- IDLE, load, aligned: dm_req=1 and stall_mem=1 (combinational). Next edge: latch type, offset and rd into internal regs, clear timeout counter, go WAIT. wb_en_wb←0 (bubble).
- WAIT, dm_rvalid=0: stall_mem=1, counter+1, wb_en_wb←0. When the counter reaches TIMEOUT-1: next edge load_timeout←1, wb_en_wb←0, go IDLE. stall_mem drops in that last cycle.
- WAIT, dm_rvalid=1: stall_mem=0. Next edge wb_data←aligned result, rd_addr_wb←latched rd, wb_en_wb←latched wb_en, go IDLE.
- Alignment: s = dm_rdata >> (8·offset).
  - LW: dm_rdata
  - LH: sext(s[15:0]); LHU: zext(s[15:0])
  - LB: sext(s[7:0]); LBU: zext(s[7:0])
  - The byte-lane mapping matches the store path's left-shift-by-offset.
- dm_rvalid while in IDLE is ignored.
- Upstream holds all *_mem inputs stable while stall_mem=1.

## Timing
- Reset (any time, including mid-WAIT): state IDLE, counter 0. wb_data=0, rd_addr_wb=0, wb_en_wb=0, load_misalign=0, load_timeout=0. The outstanding read is dropped; a later dm_rvalid is ignored.
- Non-load latency: 1 cycle to WB.
- Load latency: 1 cycle (request) + N response cycles. With N=1, the WB result appears 2 edges after the load enters MEM; stall_mem is high for exactly 1 cycle.
- dm_req is never high for two consecutive cycles.
- load_misalign and load_timeout each last exactly one cycle and are mutually exclusive.

## Test plan
- Non-load pass-through: is_load=000, alu_out=0x1234_5678, rd=5, wb_en=1 → next cycle wb_data=0x1234_5678, rd_addr_wb=5, wb_en_wb=1; no dm_req.
- LB sign: addr=0x103, rdata=0x80AA_BBCC, rvalid 1 cycle after req → dm_addr=0x100, stall 1 cycle, wb_data=0xFFFF_FF80. Same access as LBU → 0x0000_0080.
- LH offset 01: rdata=0x00F0_0F00 → wb_data=0xFFFF_F00F. LHU at offset 10, rdata=0x8001_0000 → 0x0000_8001.
- Misaligned: LW addr=0x102 → no dm_req, load_misalign=1 for one cycle, wb_en_wb=0, stall_mem=0.
- Timeout: TIMEOUT=4, LW with no rvalid → stall 4 cycles, then load_timeout pulse, wb_en_wb=0. A late rvalid is ignored.
- Reset mid-WAIT: rst_n low during WAIT → all outputs 0. After release, a non-load instruction passes through normally.
